// File: rtl/seq_divider_32bit.sv
// seq_divider_32bit
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU. One quotient bit is
// produced per cycle with a single (XLEN+1)-bit trial subtract; signed ops are
// handled by dividing magnitudes and fixing the sign in a final FIX cycle.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start     request, sampled only while busy=0
//   op        00=DIV, 01=DIVU, 10=REM, 11=REMU
//   dividend  rs1 value, sampled with start
//   divisor   rs2 value, sampled with start
//   busy      high from the cycle after an accepted start through the done cycle
//   done      one-cycle pulse, result valid in the same cycle
//   result    quotient or remainder, held until the next accepted start
module seq_divider_32bit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t state, state_next;

  logic            rem_op;
  logic            q_neg;
  logic            r_neg;
  logic [XLEN-1:0] dvs;
  // The partial remainder is always below the divisor, so its top bit of the
  // (XLEN+1)-bit form is always zero and is not stored.
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] quo;
  logic [CW-1:0]   count;

  // Operand decode on the request inputs
  logic            in_signed;
  logic            in_rem;
  logic            dvd_neg;
  logic            dvs_neg;
  logic [XLEN-1:0] dvd_abs;
  logic [XLEN-1:0] dvs_abs;
  logic            div_zero;
  logic            overflow;
  logic            special;
  logic [XLEN-1:0] special_result;

  always_comb begin
    in_signed = ~op[0];
    in_rem    = op[1];
    dvd_neg   = in_signed & dividend[XLEN-1];
    dvs_neg   = in_signed & divisor[XLEN-1];
    // |0x80000000| wraps to 0x80000000, which is correct read as unsigned
    dvd_abs   = dvd_neg ? -dividend : dividend;
    dvs_abs   = dvs_neg ? -divisor : divisor;
    div_zero  = (divisor == '0);
    overflow  = in_signed && (dividend == {1'b1, {(XLEN-1){1'b0}}}) && (divisor == '1);
    special   = div_zero | overflow;
    // Overflow quotient equals the most-negative dividend itself
    if (div_zero) begin
      special_result = in_rem ? dividend : '1;
    end else begin
      special_result = in_rem ? '0 : dividend;
    end
  end

  logic [XLEN:0]   trial;
  logic            trial_ok;
  logic [XLEN-1:0] fix_result;

  always_comb begin
    trial      = {rem, quo[XLEN-1]} - {1'b0, dvs};
    trial_ok   = ~trial[XLEN];
    fix_result = rem_op ? (r_neg ? -rem : rem) : (q_neg ? -quo : quo);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = special ? DONE : CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (count == LAST) begin
          state_next = FIX;
        end
      end
      FIX: begin
        busy       = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_op <= 1'b0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
      dvs    <= '0;
      rem    <= '0;
      quo    <= '0;
      count  <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            rem_op <= in_rem;
            q_neg  <= dvd_neg ^ dvs_neg;
            r_neg  <= dvd_neg;
            dvs    <= dvs_abs;
            rem    <= '0;
            quo    <= dvd_abs;
            count  <= '0;
            if (special) begin
              result <= special_result;
            end
          end
        end
        CALC: begin
          // Restoring step: keep the trial difference only when it did not borrow
          rem   <= trial_ok ? trial[XLEN-1:0] : {rem[XLEN-2:0], quo[XLEN-1]};
          quo   <= {quo[XLEN-2:0], trial_ok};
          count <= count + CW'(1);
        end
        FIX: begin
          result <= fix_result;
        end
        default: ;
      endcase
    end
  end

endmodule
